// File: rtl/hit_capture_pkg.sv
// Shared defaults and FSM state type for the hit_capture key-capture block.
// The HIT_DURATION_EN build option is handled in hit_capture.sv.
package hit_capture_pkg;

    localparam int unsigned HC_NOTE_KEYS   = 7;
    localparam int unsigned HC_LENGTH_KEYS = 7;
    localparam int unsigned HC_NOTE_W      = 4;
    localparam int unsigned HC_LENGTH_W    = 3;
    localparam int unsigned HC_OCT_W       = 3;
    localparam int unsigned HC_CLOCK_W     = 32;

    localparam int unsigned HC_OCT_MIN     = 0;
    localparam int unsigned HC_OCT_MAX     = 6;
    localparam int unsigned HC_OCT_RESET   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } hc_state_e;

endpackage

// File: rtl/hit_edge_pulse.sv
// Synchronous rising-edge detector: pulse_o is high in the first cycle d_i is
// sampled high after being low.
module hit_edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign pulse_o = d_i & ~prev_q;

endmodule

// File: rtl/hit_capture.sv
// Key capture: octave stepping, priority key encode and one time-stamped hit
// per press over valid/ready. Define HIT_DURATION_EN to emit on release with a duration.
module hit_capture
    import hit_capture_pkg::*;
#(
    parameter int unsigned NOTE_KEYS   = HC_NOTE_KEYS,
    parameter int unsigned LENGTH_KEYS = HC_LENGTH_KEYS,
    parameter int unsigned NOTE_W      = HC_NOTE_W,
    parameter int unsigned LENGTH_W    = HC_LENGTH_W,
    parameter int unsigned OCT_W       = HC_OCT_W,
    parameter int unsigned OCT_MIN     = HC_OCT_MIN,
    parameter int unsigned OCT_MAX     = HC_OCT_MAX,
    parameter int unsigned OCT_RESET   = HC_OCT_RESET,
    parameter int unsigned CLOCK_W     = HC_CLOCK_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            oct_up,
    input  logic                            oct_down,
    input  logic [NOTE_KEYS-1:0]            note_key,
    input  logic [LENGTH_KEYS-1:0]          length_key,
    input  logic [NOTE_KEYS*NOTE_W-1:0]     trans_note,
    input  logic [LENGTH_KEYS*LENGTH_W-1:0] trans_length,
    input  logic [CLOCK_W-1:0]              system_clock,
    input  logic                            hit_ready,
    output logic                            hit_valid,
    output logic [OCT_W-1:0]                hit_octave,
    output logic [NOTE_W-1:0]               hit_note,
    output logic [LENGTH_W-1:0]             hit_length,
    output logic [CLOCK_W-1:0]              hit_stamp,
    output logic [OCT_W-1:0]                octave,
    output logic                            dropped
`ifdef HIT_DURATION_EN
    ,
    output logic [CLOCK_W-1:0]              hit_duration
`endif
);

    function automatic logic [NOTE_W-1:0] enc_note(
        input logic [NOTE_KEYS-1:0]        keys,
        input logic [NOTE_KEYS*NOTE_W-1:0] tab
    );
        logic found;
        enc_note = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NOTE_KEYS; i++) begin
            if (keys[i] && !found) begin
                enc_note = tab[i*NOTE_W +: NOTE_W];
                found    = 1'b1;
            end
        end
    endfunction

    function automatic logic [LENGTH_W-1:0] enc_length(
        input logic [LENGTH_KEYS-1:0]          keys,
        input logic [LENGTH_KEYS*LENGTH_W-1:0] tab
    );
        logic found;
        enc_length = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < LENGTH_KEYS; i++) begin
            if (keys[i] && !found) begin
                enc_length = tab[i*LENGTH_W +: LENGTH_W];
                found      = 1'b1;
            end
        end
    endfunction

    logic                up_pulse;
    logic                down_pulse;
    logic [OCT_W-1:0]    octave_q,    octave_d;
    logic [LENGTH_W-1:0] len_latch_q, len_latch_d;

    hc_state_e           state_q;
    logic                valid_q;
    logic [OCT_W-1:0]    hoct_q;
    logic [NOTE_W-1:0]   hnote_q;
    logic [LENGTH_W-1:0] hlen_q;
    logic [CLOCK_W-1:0]  hstamp_q;
    logic                dropped_q;

    logic                any_note;
    logic [NOTE_W-1:0]   note_code;
    logic [LENGTH_W-1:0] len_code;
    logic                press;
    logic                emit;
    logic                transfer;
    logic                slot_free;
    logic [OCT_W-1:0]    ev_octave;
    logic [NOTE_W-1:0]   ev_note;
    logic [LENGTH_W-1:0] ev_len;
    logic [CLOCK_W-1:0]  ev_stamp;

`ifdef HIT_DURATION_EN
    logic [OCT_W-1:0]    p_octave_q;
    logic [NOTE_W-1:0]   p_note_q;
    logic [LENGTH_W-1:0] p_len_q;
    logic [CLOCK_W-1:0]  p_stamp_q;
    logic [CLOCK_W-1:0]  hdur_q;
    logic [CLOCK_W-1:0]  ev_dur;
`endif

    hit_edge_pulse u_up_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (oct_up),
        .pulse_o (up_pulse)
    );

    hit_edge_pulse u_down_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (oct_down),
        .pulse_o (down_pulse)
    );

    always_comb begin
        any_note    = |note_key;
        note_code   = enc_note(note_key, trans_note);
        len_code    = (|length_key) ? enc_length(length_key, trans_length) : len_latch_q;
        len_latch_d = len_code;

        octave_d = octave_q;
        if (up_pulse && !down_pulse && (octave_q < OCT_W'(OCT_MAX))) begin
            octave_d = octave_q + 1'b1;
        end else if (down_pulse && !up_pulse && (octave_q > OCT_W'(OCT_MIN))) begin
            octave_d = octave_q - 1'b1;
        end

        transfer  = valid_q & hit_ready;
        slot_free = ~valid_q | transfer;
        press     = en & (state_q == IDLE) & any_note;

`ifdef HIT_DURATION_EN
        // Payload comes from the press record; the event fires on release.
        emit      = en & (state_q == HELD) & ~any_note;
        ev_octave = p_octave_q;
        ev_note   = p_note_q;
        ev_len    = p_len_q;
        ev_stamp  = p_stamp_q;
        ev_dur    = system_clock - p_stamp_q;
`else
        emit      = press;
        ev_octave = octave_q;
        ev_note   = note_code;
        ev_len    = len_code;
        ev_stamp  = system_clock;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            octave_q    <= OCT_W'(OCT_RESET);
            len_latch_q <= '0;
        end else begin
            octave_q    <= octave_d;
            len_latch_q <= len_latch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            hoct_q     <= '0;
            hnote_q    <= '0;
            hlen_q     <= '0;
            hstamp_q   <= '0;
            dropped_q  <= 1'b0;
`ifdef HIT_DURATION_EN
            hdur_q     <= '0;
            p_octave_q <= '0;
            p_note_q   <= '0;
            p_len_q    <= '0;
            p_stamp_q  <= '0;
`endif
        end else begin
            if (transfer) begin
                valid_q <= 1'b0;
            end
            // A transfer in the same cycle frees the slot for the new event.
            if (emit) begin
                if (slot_free) begin
                    valid_q  <= 1'b1;
                    hoct_q   <= ev_octave;
                    hnote_q  <= ev_note;
                    hlen_q   <= ev_len;
                    hstamp_q <= ev_stamp;
`ifdef HIT_DURATION_EN
                    hdur_q   <= ev_dur;
`endif
                end else begin
                    dropped_q <= 1'b1;
                end
            end
`ifdef HIT_DURATION_EN
            if (press) begin
                p_octave_q <= octave_q;
                p_note_q   <= note_code;
                p_len_q    <= len_code;
                p_stamp_q  <= system_clock;
            end
`endif
            if (!en) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE:    if (any_note)  state_q <= HELD;
                    HELD:    if (!any_note) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign hit_valid  = valid_q;
    assign hit_octave = hoct_q;
    assign hit_note   = hnote_q;
    assign hit_length = hlen_q;
    assign hit_stamp  = hstamp_q;
    assign octave     = octave_q;
    assign dropped    = dropped_q;
`ifdef HIT_DURATION_EN
    assign hit_duration = hdur_q;
`endif

endmodule
